// File: rtl/cla_nibble_serial_adder.sv
// Serial WIDTH-bit adder reusing one 4-bit carry-lookahead slice,
// one nibble per clock, LSB nibble first, with start/done handshake.
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16,
    localparam int NIB = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [3:0] an;
    logic [3:0] bn;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] s;

    // Shared lookahead slice fed by the current nibble and the carry register
    always_comb begin
        an = a_reg[{idx, 2'b00} +: 4];
        bn = b_reg[{idx, 2'b00} +: 4];
        p  = an ^ bn;
        g  = an & bn;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s = p ^ c[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        idx   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= s;
                    carry <= c[4];
                    if (idx == LAST) begin
                        cout  <= c[4];
                        ovf   <= c[4] ^ c[3];
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for cla_nibble_serial_adder: 16-bit and 4-bit builds.
module tb_cla_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        ovf4;

    int n_cmp;
    int n_bad;
    int lat;
    int bcnt;
    int dcnt;

    cla_nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    cla_nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4),
        .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one add, then wait (bounded) for done; lat counts edges
    task automatic do_add(input logic [15:0] av, input logic [15:0] bv,
                          input logic ci);
        a = av;
        b = bv;
        cin = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        cin4 = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        // basic add, latency, busy width
        do_add(16'h1234, 16'h4321, 1'b0);
        check("t1_lat", lat, 4);
        check("t1_sum", sum, 16'h5555);
        check("t1_cout", cout, 0);
        check("t1_ovf", ovf, 0);
        tick();
        check("t1_done_low", done, 0);
        check("t1_busy", bcnt, 5);
        check("t1_busy_low", busy, 0);
        check("t1_sum_hold", sum, 16'h5555);

        // full ripple
        do_add(16'hFFFF, 16'h0001, 1'b0);
        check("t2a_sum", sum, 16'h0000);
        check("t2a_cout", cout, 1);
        check("t2a_ovf", ovf, 0);
        tick();
        tick();
        check("t2a_cout_hold", cout, 1);
        a = 16'h0000;
        b = 16'h0000;
        cin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2b_cout_clr", cout, 0);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("t2b_lat", lat, 4);
        check("t2b_sum", sum, 16'h0001);
        check("t2b_cout", cout, 0);
        tick();

        // signed overflow
        do_add(16'h7FFF, 16'h0001, 1'b0);
        check("t3a_sum", sum, 16'h8000);
        check("t3a_cout", cout, 0);
        check("t3a_ovf", ovf, 1);
        tick();
        do_add(16'h8000, 16'h8000, 1'b0);
        check("t3b_sum", sum, 16'h0000);
        check("t3b_cout", cout, 1);
        check("t3b_ovf", ovf, 1);
        tick();

        // start held high, operands changed mid-run
        a = 16'h000E;
        b = 16'h0001;
        cin = 1'b1;
        start = 1'b1;
        tick();
        a = 16'hAAAA;
        b = 16'h5555;
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("t4_lat", lat, 4);
        check("t4_sum", sum, 16'h0010);
        check("t4_cout", cout, 0);
        tick();
        check("t4_done_once", done, 0);
        check("t4_idle", busy, 0);
        tick();
        check("t4_restart", busy, 1);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("t4b_lat", lat, 4);
        check("t4b_sum", sum, 16'h0000);
        check("t4b_cout", cout, 1);
        check("t4b_ovf", ovf, 0);
        tick();

        // reset mid-run
        a = 16'h1111;
        b = 16'h1111;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_sum", sum, 0);
        check("t5_cout", cout, 0);
        check("t5_ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) dcnt++;
        end
        check("t5_no_done", dcnt, 0);
        do_add(16'h0909, 16'h0909, 1'b1);
        check("t5_lat", lat, 4);
        check("t5_sum2", sum, 16'h1213);
        check("t5_cout2", cout, 0);
        tick();

        // WIDTH=4 build
        a4 = 4'd9;
        b4 = 4'd9;
        cin4 = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("t6_busy", busy4, 1);
        check("t6_done_e0", done4, 0);
        tick();
        check("t6_done_e1", done4, 1);
        check("t6_sum", sum4, 4'd3);
        check("t6_cout", cout4, 1);
        check("t6_ovf", ovf4, 1);
        tick();
        check("t6_done_e2", done4, 0);
        check("t6_busy_e2", busy4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_nibble_serial_adder.md
Name: cla_nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder controller that time-shares one 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
- The slice is the team's carry_look_ahead_4bit or equivalent logic.
- Carry is held in a register between nibbles.
- Sits between a requester using a start/done handshake and the single CLA slice. Used where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when result is valid
- sum  output  WIDTH  result; held until next accepted start
- cout  output  1  carry out of MSB
- ovf  output  1  two's-complement overflow, equal to carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; nibble index goes to 0.
  - Carry register, operand registers, sum, cout, ovf, busy and done all go to 0.
  - Reset during RUN or DONE discards the operation; no done pulse follows.
- State machine, with transitions on rising clk:
  - IDLE: start=1 latches a, b and cin into internal registers, sets index to 0, goes to RUN. start=0 stays in IDLE.
  - RUN: the slice adds a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry register.
    - Writes sum[4i+3:4i] and sets carry register to the slice carry-out.
    - Index increments.
    - When i=NIB-1, latches cout and ovf from the final nibble, then goes to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE unconditionally.
- Latency: with start accepted at edge 0, done is high in the cycle after edge NIB. For WIDTH=16, done is high after edge 4 and returns low at edge 5.
- Throughput: one add per NIB+2 cycles at best.
- start rules:
  - start in RUN or DONE is ignored and not queued.
  - Operand changes after the accepting edge have no effect.
- Output stability:
  - Sum nibbles update progressively during RUN. Consumers use sum only when done=1 or in later IDLE cycles.
  - sum, cout and ovf hold their values in IDLE until the next accepted start.
  - On an accepted start, cout and ovf clear to 0.
- Arithmetic:
  - {cout,sum} = a + b + cin, an exact (WIDTH+1)-bit result.
  - Carry propagates across nibble boundaries only through the carry register, never combinationally.
- WIDTH=4: NIB=1, RUN lasts one cycle, done is high after edge 1.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x4321, cin=0, start pulsed 1 cycle -> done is high exactly after edge 4; sum=0x5555, cout=0, ovf=0; busy is high for 5 cycles.
2. a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 nibbles; sum=0x0000, cout=1, ovf=0. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
3. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
4. Start 0x000E+0x0001, cin=1. Then hold start high and change a and b to 0xAAAA/0x5555 during RUN and DONE -> result is still sum=0x0010, cout=0. Exactly one done pulse; the second add begins only from IDLE, and only if start is still high there.
5. Drive rst_n low mid-RUN, after 2 nibbles -> busy, done, sum, cout and ovf are immediately 0 and state is IDLE. After release, a=0x0909, b=0x0909, cin=1 -> sum=0x1213, cout=0.
6. WIDTH=4 build: a=9, b=9, cin=1 -> sum=3, cout=1, ovf=1, done high after edge 1.
